// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the multi-issue hazard unit:
//   hazard_state_t  - sequencer states (RUN, LU_STALL, FLUSH, FREEZE)
//   REG_ZERO        - the hardwired-zero register index
//   *_MIN / *_MAX   - supported parameter ranges
//   SEQ_CNT_W       - width of the bubble/flush sequencing counter
//   lane_lsb()      - low bit of lane N in a packed per-lane bus
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    FREEZE   = 2'd3
  } hazard_state_t;

  localparam int REG_ZERO = 0;

  localparam int ISSUE_WIDTH_MIN = 1;
  localparam int ISSUE_WIDTH_MAX = 4;
  localparam int LOAD_USE_MIN    = 1;
  localparam int LOAD_USE_MAX    = 3;
  localparam int FLUSH_MIN       = 1;
  localparam int FLUSH_MAX       = 2;

  // Large enough to hold LOAD_USE_MAX-1 and FLUSH_MAX-1
  localparam int SEQ_CNT_W = 2;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/hazard_lane_cmp.sv
// hazard_lane_cmp
// Combinational check of one source pair against one destination register.
// Ports:
//   rs, rt  - source register indices of the consuming instruction
//   dst     - destination register index of the producing instruction
//   match   - high when dst is non-zero and equals rs or rt
module hazard_lane_cmp
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] dst,
  output logic             match
);

  // Writes to x0 are discarded by the register file, so they never conflict
  assign match = (dst != REG_W'(REG_ZERO)) && ((rs == dst) || (rt == dst));

endmodule

// File: rtl/hazard_unit_mw.sv
// hazard_unit_mw
// Multi-issue hazard unit between IF/ID and ID/EX. Decides per cycle which
// IF/ID lanes enter ID/EX, inserts load-use bubbles, splits bundles with
// intra-bundle RAW dependencies, sequences IF flushes and freezes the front
// end while data memory is busy.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   id_ex_mem_read            - per-lane load flag in ID/EX
//   id_ex_destination_reg     - packed ID/EX destination registers
//   if_id_valid               - per-lane valid in IF/ID
//   if_id_rs, if_id_rt        - packed IF/ID source registers
//   if_id_rd, if_id_reg_write - packed IF/ID destinations and write enables
//   branch_taken, jump        - redirect request
//   mem_busy                  - data memory not ready
//   Data_Hazard               - hold PC and IF/ID, bubble unissued lanes
//   IF_Flush                  - squash IF/ID
//   pc_write_en               - PC may update
//   issue_mask                - lanes moving into ID/EX this cycle
//   stall_cycles              - saturating count of Data_Hazard cycles
module hazard_unit_mw
  import hazard_pkg::*;
#(
  parameter int ISSUE_WIDTH     = 2,
  parameter int REG_W           = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ISSUE_WIDTH-1:0]       id_ex_mem_read,
  input  logic [ISSUE_WIDTH*REG_W-1:0] id_ex_destination_reg,
  input  logic [ISSUE_WIDTH-1:0]       if_id_valid,
  input  logic [ISSUE_WIDTH*REG_W-1:0] if_id_rs,
  input  logic [ISSUE_WIDTH*REG_W-1:0] if_id_rt,
  input  logic [ISSUE_WIDTH*REG_W-1:0] if_id_rd,
  input  logic [ISSUE_WIDTH-1:0]       if_id_reg_write,
  input  logic                         branch_taken,
  input  logic                         jump,
  input  logic                         mem_busy,
  output logic                         Data_Hazard,
  output logic                         IF_Flush,
  output logic                         pc_write_en,
  output logic [ISSUE_WIDTH-1:0]       issue_mask,
  output logic [CNT_W-1:0]             stall_cycles
);

  // Out-of-range sequencing lengths are clamped into the supported range
  localparam int LU_LEN = (LOAD_USE_CYCLES < LOAD_USE_MIN) ? LOAD_USE_MIN :
                          (LOAD_USE_CYCLES > LOAD_USE_MAX) ? LOAD_USE_MAX : LOAD_USE_CYCLES;
  localparam int FL_LEN = (FLUSH_CYCLES < FLUSH_MIN) ? FLUSH_MIN :
                          (FLUSH_CYCLES > FLUSH_MAX) ? FLUSH_MAX : FLUSH_CYCLES;
  localparam int NPAIR  = ISSUE_WIDTH * ISSUE_WIDTH;

  hazard_state_t          state;
  logic [SEQ_CNT_W-1:0]   cnt;
  logic [ISSUE_WIDTH-1:0] issued_mask;
  logic [CNT_W-1:0]       stall_cnt;

  logic [ISSUE_WIDTH-1:0] pending;
  logic [NPAIR-1:0]       lu_match;
  logic [NPAIR-1:0]       raw_match;
  logic [ISSUE_WIDTH-1:0] raw_dep;
  logic [ISSUE_WIDTH-1:0] split_mask;
  logic                   lu_hit;
  logic                   split_hit;
  logic                   redirect;

  assign redirect = branch_taken | jump;
  assign pending  = if_id_valid & ~issued_mask;

  // Comparator matrix: pair index is consumer*ISSUE_WIDTH + producer.
  // The RAW matrix is built in full; only producer < consumer is used below.
  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_src
    for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_dst
      hazard_lane_cmp #(.REG_W(REG_W)) u_lu_cmp (
        .rs    (if_id_rs[lane_lsb(i, REG_W) +: REG_W]),
        .rt    (if_id_rt[lane_lsb(i, REG_W) +: REG_W]),
        .dst   (id_ex_destination_reg[lane_lsb(j, REG_W) +: REG_W]),
        .match (lu_match[i*ISSUE_WIDTH+j])
      );
      hazard_lane_cmp #(.REG_W(REG_W)) u_raw_cmp (
        .rs    (if_id_rs[lane_lsb(i, REG_W) +: REG_W]),
        .rt    (if_id_rt[lane_lsb(i, REG_W) +: REG_W]),
        .dst   (if_id_rd[lane_lsb(j, REG_W) +: REG_W]),
        .match (raw_match[i*ISSUE_WIDTH+j])
      );
    end
  end

  // Hazard detection over unissued lanes: any load-use pair, and the lowest
  // lane that reads a register written by an older lane of the same bundle.
  // Everything below that lane may issue now; the rest waits.
  always_comb begin
    lu_hit     = 1'b0;
    split_hit  = 1'b0;
    split_mask = '0;
    raw_dep    = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (pending[i] && id_ex_mem_read[j] && lu_match[i*ISSUE_WIDTH+j])
          lu_hit = 1'b1;
        if ((j < i) && pending[j] && if_id_reg_write[j] && raw_match[i*ISSUE_WIDTH+j])
          raw_dep[i] = 1'b1;
      end
    end
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (!split_hit && pending[k] && raw_dep[k]) begin
        split_hit = 1'b1;
        for (int j = 0; j < ISSUE_WIDTH; j++)
          if (j < k) split_mask[j] = pending[j];
      end
    end
  end

  // Output decode: reset forces the idle pattern, a redirect overrides any
  // state, otherwise the state and the RUN-time priority chain decide.
  always_comb begin
    Data_Hazard = 1'b0;
    IF_Flush    = 1'b0;
    pc_write_en = 1'b1;
    issue_mask  = '0;
    if (reset) begin
      Data_Hazard = 1'b0;
    end else if (redirect) begin
      IF_Flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy || lu_hit) begin
            Data_Hazard = 1'b1;
            pc_write_en = 1'b0;
          end else if (split_hit) begin
            Data_Hazard = 1'b1;
            pc_write_en = 1'b0;
            issue_mask  = split_mask;
          end else begin
            issue_mask = pending;
          end
        end
        LU_STALL, FREEZE: begin
          Data_Hazard = 1'b1;
          pc_write_en = 1'b0;
        end
        FLUSH: begin
          IF_Flush = 1'b1;
        end
        default: begin
          Data_Hazard = 1'b0;
        end
      endcase
    end
  end

  assign stall_cycles = reset ? '0 : stall_cnt;

  // Sequencer state, bubble/flush counter, issued-lane tracking and the
  // saturating stall counter. LU_STALL holds its count while memory is busy
  // so the bubble count is extended rather than consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      issued_mask <= '0;
      stall_cnt   <= '0;
    end else begin
      if (Data_Hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect) begin
        issued_mask <= '0;
        if (FL_LEN > 1) begin
          state <= FLUSH;
          cnt   <= SEQ_CNT_W'(FL_LEN - 1);
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end else begin
        case (state)
          RUN: begin
            if (mem_busy) begin
              state <= FREEZE;
            end else if (lu_hit) begin
              if (LU_LEN > 1) begin
                state <= LU_STALL;
                cnt   <= SEQ_CNT_W'(LU_LEN - 1);
              end
            end else if (split_hit) begin
              issued_mask <= issued_mask | split_mask;
            end else begin
              issued_mask <= '0;
            end
          end
          LU_STALL: begin
            if (!mem_busy) begin
              if (cnt == SEQ_CNT_W'(1)) state <= RUN;
              cnt <= cnt - SEQ_CNT_W'(1);
            end
          end
          FLUSH: begin
            if (cnt == SEQ_CNT_W'(1)) state <= RUN;
            cnt <= cnt - SEQ_CNT_W'(1);
          end
          FREEZE: begin
            if (!mem_busy) state <= RUN;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mw.sv
// tb_hazard_unit_mw
// Directed bench for hazard_unit_mw. Instance dut_a uses the default
// parameters; dut_b uses LOAD_USE_CYCLES=3 and FLUSH_CYCLES=2. Both share
// the same stimulus; each step checks whichever instance it targets.
module tb_hazard_unit_mw;

  logic        clk;
  logic        reset;
  logic [1:0]  id_ex_mem_read;
  logic [9:0]  id_ex_destination_reg;
  logic [1:0]  if_id_valid;
  logic [9:0]  if_id_rs;
  logic [9:0]  if_id_rt;
  logic [9:0]  if_id_rd;
  logic [1:0]  if_id_reg_write;
  logic        branch_taken;
  logic        jump;
  logic        mem_busy;

  logic        dh_a, fl_a, pcw_a;
  logic [1:0]  im_a;
  logic [15:0] sc_a;
  logic        dh_b, fl_b, pcw_b;
  logic [1:0]  im_b;
  logic [15:0] sc_b;

  int vectors;
  int miscompares;

  hazard_unit_mw dut_a (
    .clk                   (clk),
    .reset                 (reset),
    .id_ex_mem_read        (id_ex_mem_read),
    .id_ex_destination_reg (id_ex_destination_reg),
    .if_id_valid           (if_id_valid),
    .if_id_rs              (if_id_rs),
    .if_id_rt              (if_id_rt),
    .if_id_rd              (if_id_rd),
    .if_id_reg_write       (if_id_reg_write),
    .branch_taken          (branch_taken),
    .jump                  (jump),
    .mem_busy              (mem_busy),
    .Data_Hazard           (dh_a),
    .IF_Flush              (fl_a),
    .pc_write_en           (pcw_a),
    .issue_mask            (im_a),
    .stall_cycles          (sc_a)
  );

  hazard_unit_mw #(
    .LOAD_USE_CYCLES (3),
    .FLUSH_CYCLES    (2)
  ) dut_b (
    .clk                   (clk),
    .reset                 (reset),
    .id_ex_mem_read        (id_ex_mem_read),
    .id_ex_destination_reg (id_ex_destination_reg),
    .if_id_valid           (if_id_valid),
    .if_id_rs              (if_id_rs),
    .if_id_rt              (if_id_rt),
    .if_id_rd              (if_id_rd),
    .if_id_reg_write       (if_id_reg_write),
    .branch_taken          (branch_taken),
    .jump                  (jump),
    .mem_busy              (mem_busy),
    .Data_Hazard           (dh_b),
    .IF_Flush              (fl_b),
    .pc_write_en           (pcw_b),
    .issue_mask            (im_b),
    .stall_cycles          (sc_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle's inputs on the falling edge, then settle before checks
  task automatic applyStimulus(
    input logic       rst,
    input logic [1:0] valid,
    input logic [9:0] rs,
    input logic [9:0] rt,
    input logic [9:0] rd,
    input logic [1:0] rw,
    input logic [1:0] mr,
    input logic [9:0] dest,
    input logic       jmp,
    input logic       busy
  );
    @(negedge clk);
    reset                 = rst;
    if_id_valid           = valid;
    if_id_rs              = rs;
    if_id_rt              = rt;
    if_id_rd              = rd;
    if_id_reg_write       = rw;
    id_ex_mem_read        = mr;
    id_ex_destination_reg = dest;
    branch_taken          = 1'b0;
    jump                  = jmp;
    mem_busy              = busy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Lane packing: {lane1, lane0}, 5 bits per lane
  localparam logic [9:0] RS_LU   = {5'd1, 5'd5};
  localparam logic [9:0] RT_LU   = {5'd2, 5'd3};
  localparam logic [9:0] DEST5   = {5'd0, 5'd5};
  localparam logic [9:0] ZERO10  = 10'd0;

  initial begin
    vectors               = 0;
    miscompares           = 0;
    reset                 = 1'b1;
    id_ex_mem_read        = '0;
    id_ex_destination_reg = '0;
    if_id_valid           = '0;
    if_id_rs              = '0;
    if_id_rt              = '0;
    if_id_rd              = '0;
    if_id_reg_write       = '0;
    branch_taken          = 1'b0;
    jump                  = 1'b0;
    mem_busy              = 1'b0;

    // Reset with a hazard pattern present: outputs forced idle
    applyStimulus(1, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 1);
    checkOutput("rst_dh", dh_a, 0);
    checkOutput("rst_flush", fl_a, 0);
    checkOutput("rst_pcw", pcw_a, 1);
    checkOutput("rst_issue", im_a, 0);
    checkOutput("rst_stall", sc_a, 0);
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);

    // Load-use, single bubble on dut_a, then the bundle issues
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 0);
    checkOutput("lu_dh", dh_a, 1);
    checkOutput("lu_pcw", pcw_a, 0);
    checkOutput("lu_issue", im_a, 2'b00);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("lu_after_issue", im_a, 2'b11);
    checkOutput("lu_after_dh", dh_a, 0);
    checkOutput("lu_after_pcw", pcw_a, 1);
    checkOutput("lu_after_stall", sc_a, 1);
    checkOutput("lu_b_still_stalled", dh_b, 1);

    // Load into x0 never creates a hazard
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, ZERO10, ZERO10, ZERO10, 2'b00, 2'b01, ZERO10, 0, 0);
    checkOutput("x0_issue", im_a, 2'b11);
    checkOutput("x0_dh", dh_a, 0);

    // Intra-bundle RAW: lane0 writes x3, lane1 reads x3
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, {5'd3, 5'd1}, {5'd4, 5'd2}, {5'd0, 5'd3}, 2'b01, 2'b00, ZERO10, 0, 0);
    checkOutput("split1_issue", im_a, 2'b01);
    checkOutput("split1_dh", dh_a, 1);
    checkOutput("split1_pcw", pcw_a, 0);
    applyStimulus(0, 2'b11, {5'd3, 5'd1}, {5'd4, 5'd2}, {5'd0, 5'd3}, 2'b01, 2'b00, ZERO10, 0, 0);
    checkOutput("split2_issue", im_a, 2'b10);
    checkOutput("split2_dh", dh_a, 0);
    checkOutput("split2_stall", sc_a, 1);

    // Jump with concurrent load-use: dut_b flushes two cycles, no stall
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 1, 0);
    checkOutput("jmp1_flush_b", fl_b, 1);
    checkOutput("jmp1_dh_b", dh_b, 0);
    checkOutput("jmp1_issue_b", im_b, 2'b00);
    checkOutput("jmp1_pcw_b", pcw_b, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 0);
    checkOutput("jmp2_flush_b", fl_b, 1);
    checkOutput("jmp2_dh_b", dh_b, 0);
    checkOutput("jmp2_issue_b", im_b, 2'b00);
    checkOutput("jmp2_stall_b", sc_b, 0);
    checkOutput("jmp2_flush_a", fl_a, 0);
    checkOutput("jmp2_dh_a", dh_a, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 0);
    checkOutput("jmp3_flush_b", fl_b, 0);
    checkOutput("jmp3_dh_b", dh_b, 1);

    // Three-bubble load-use on dut_b, memory busy during the second bubble
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 0);
    checkOutput("lu3_c1_dh", dh_b, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 1);
    checkOutput("lu3_c2_dh", dh_b, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 1);
    checkOutput("lu3_c3_dh", dh_b, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("lu3_c4_dh", dh_b, 1);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("lu3_c5_dh", dh_b, 1);
    checkOutput("lu3_c5_pcw", pcw_b, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("lu3_c6_dh", dh_b, 0);
    checkOutput("lu3_c6_issue", im_b, 2'b11);
    checkOutput("lu3_c6_stall", sc_b, 5);

    // Memory busy freezes dut_a; release takes effect a cycle later
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 1);
    checkOutput("frz1_dh", dh_a, 1);
    checkOutput("frz1_issue", im_a, 2'b00);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("frz2_dh", dh_a, 1);
    checkOutput("frz2_pcw", pcw_a, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("frz3_issue", im_a, 2'b11);
    checkOutput("frz3_stall", sc_a, 2);

    // Reset in the middle of an LU_STALL on dut_b
    applyStimulus(1, 2'b00, ZERO10, ZERO10, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b01, DEST5, 0, 0);
    checkOutput("rlu_c1_dh", dh_b, 1);
    applyStimulus(1, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("rlu_rst_dh", dh_b, 0);
    checkOutput("rlu_rst_flush", fl_b, 0);
    checkOutput("rlu_rst_pcw", pcw_b, 1);
    checkOutput("rlu_rst_issue", im_b, 2'b00);
    checkOutput("rlu_rst_stall", sc_b, 0);
    applyStimulus(0, 2'b11, RS_LU, RT_LU, ZERO10, 2'b00, 2'b00, ZERO10, 0, 0);
    checkOutput("rlu_run_issue", im_b, 2'b11);
    checkOutput("rlu_run_dh", dh_b, 0);
    checkOutput("rlu_run_stall", sc_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mw.md
# hazard_unit_mw

Multi-issue successor to the single-lane hazard detector for the superscalar 5-stage RISC-V pipeline. It sits between IF/ID and ID/EX and decides, per cycle, which IF/ID lanes may enter ID/EX. It inserts load-use bubbles of configurable length and serialises intra-bundle RAW dependencies. It also sequences multi-cycle IF flushes on redirect and freezes the front end while data memory is busy.

## Interface
Parameters:
- ISSUE_WIDTH, 2, lanes per IF/ID and ID/EX bundle (1..4)
- REG_W, 5, register address width
- LOAD_USE_CYCLES, 1, bubbles per load-use hazard (1..3)
- FLUSH_CYCLES, 1, cycles IF_Flush is held per redirect (1..2)
- CNT_W, 16, stall counter width

Ports (lane i of a packed bus occupies [i*REG_W +: REG_W]):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_ex_mem_read  in  ISSUE_WIDTH  lane in ID/EX is a load
- id_ex_destination_reg  in  ISSUE_WIDTH*REG_W  ID/EX destination registers
- if_id_valid  in  ISSUE_WIDTH  IF/ID lane holds an instruction
- if_id_rs, if_id_rt  in  ISSUE_WIDTH*REG_W  IF/ID source registers
- if_id_rd  in  ISSUE_WIDTH*REG_W  IF/ID destination registers
- if_id_reg_write  in  ISSUE_WIDTH  IF/ID lane writes rd
- branch_taken, jump  in  1  redirect request
- mem_busy  in  1  data memory not ready
- Data_Hazard  out  1  hold PC and IF/ID; bubble unissued lanes
- IF_Flush  out  1  squash IF/ID
- pc_write_en  out  1  PC may update
- issue_mask  out  ISSUE_WIDTH  lanes moving into ID/EX this cycle
- stall_cycles  out  CNT_W  saturating count of Data_Hazard cycles

## Operation
- The register file has register 0 hardwired to zero, so a destination of 0 never creates a hazard.
- Load-use is detected when any pair (i, j) satisfies all of:
  - IF/ID lane i is valid and not yet issued.
  - ID/EX lane j is a load (id_ex_mem_read[j]).
  - id_ex_destination_reg[j] is non-zero.
  - if_id_rs[i] or if_id_rt[i] equals id_ex_destination_reg[j].
- Split is detected at the lowest lane k with a RAW dependency on a lower lane. This holds when some lane j < k satisfies all of:
  - Lane j is valid and unissued.
  - if_id_reg_write[j] is set and if_id_rd[j] is non-zero.
  - if_id_rd[j] equals if_id_rs[k] or if_id_rt[k].
- An issued_mask register records lanes already issued from the current bundle. Issued lanes are excluded from both checks. issued_mask clears whenever a full issue, a redirect or a reset occurs.
- FSM states: RUN, LU_STALL, FLUSH, FREEZE. Redirect (branch_taken or jump) has priority in every state.
- Redirect, in any state:
  - Outputs: IF_Flush=1, Data_Hazard=0, pc_write_en=1, issue_mask=0.
  - If FLUSH_CYCLES>1, next state is FLUSH with cnt=FLUSH_CYCLES-1; otherwise next state is RUN.
- RUN, when there is no redirect, applies the following in priority order:
  - mem_busy: Data_Hazard=1, pc_write_en=0, issue_mask=0; go to FREEZE.
  - Load-use: Data_Hazard=1, pc_write_en=0, issue_mask=0. If LOAD_USE_CYCLES>1, go to LU_STALL with cnt=LOAD_USE_CYCLES-1; otherwise stay in RUN.
  - Split: issue_mask = valid, unissued lanes below k; Data_Hazard=1; pc_write_en=0; OR those lanes into issued_mask.
  - Otherwise: issue_mask = valid and not issued; Data_Hazard=0; pc_write_en=1.
- LU_STALL:
  - Outputs as for a load-use stall; ID/EX inputs are ignored.
  - cnt decrements each cycle; move to RUN in the cycle cnt==1.
  - While mem_busy=1, cnt holds.
- FLUSH:
  - Outputs as for a redirect.
  - cnt decrements; move to RUN at cnt==1.
  - A new redirect reloads cnt.
- FREEZE:
  - Outputs as for the mem_busy stall.
  - Next state is RUN once mem_busy=0; evaluation resumes the following cycle.
- stall_cycles increments every cycle with Data_Hazard=1 and saturates at all-ones.

## Timing
- All outputs are combinational from registered state plus current inputs, so detection has 0-cycle latency. State, cnt, issued_mask and stall_cycles update on rising clk.
- While reset is high, outputs are forced: Data_Hazard=0, IF_Flush=0, pc_write_en=1, issue_mask=0, stall_cycles=0. The next state is RUN with cnt=0 and issued_mask=0.
- Reset wins over everything, including mid-LU_STALL, FLUSH or FREEZE.
- Load-use inserts exactly LOAD_USE_CYCLES bubbles, plus any mem_busy cycles.
- IF_Flush is held for FLUSH_CYCLES consecutive cycles starting in the redirect cycle.
- A split bundle drains in at most ISSUE_WIDTH cycles when no other event occurs.

## Structure
- Package hazard_pkg contains:
  - the state enum (RUN, LU_STALL, FLUSH, FREEZE);
  - REG_ZERO;
  - parameter range constants;
  - a lane-slice helper function.
- Sub-module hazard_lane_cmp: combinational match of one source pair (rs, rt) against one destination, with a zero-register guard. It is instantiated per lane pair.

## Test plan
- Defaults; id_ex lane0 is a load with dest=5; IF/ID lane0 rs=5, rt=3 -> Data_Hazard=1, pc_write_en=0, issue_mask=00 for one cycle; next cycle issue_mask=11; stall_cycles=1.
- Load with dest=0; rs=0 -> no hazard; issue_mask=11.
- Lane0 rd=3 with reg_write; lane1 rs=3 -> cycle 1: issue_mask=01, Data_Hazard=1; cycle 2: issue_mask=10, Data_Hazard=0.
- FLUSH_CYCLES=2; jump=1 with a concurrent load-use -> IF_Flush=1 for 2 cycles, Data_Hazard=0, issue_mask=00, stall_cycles unchanged.
- LOAD_USE_CYCLES=3; mem_busy=1 for 2 cycles during the 2nd stall cycle -> 5 stall cycles total, stall_cycles=5.
- Reset asserted in LU_STALL -> outputs forced inactive in that cycle; next cycle RUN with stall_cycles=0.
